// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Bundles the GPU data-memory request/response signals for all channels.
//   Every signal is a per-channel vector. Index [i] belongs to channel i.
//   master modport: GPU (initiator) side; it drives valid/address/write data.
//   slave modport : memory (responder) side; it drives ready and read data.
//   Signals:
//     read_valid    [N]            read request
//     read_address  [N][ADDR]      read word address
//     read_ready    [N]            read acknowledge, read_data valid while high
//     read_data     [N][DATA]      read result
//     write_valid   [N]            write request
//     write_address [N][ADDR]      write word address
//     write_data    [N][DATA]      write word
//     write_ready   [N]            write acknowledge
interface data_mem_responder_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32
);
  logic [NUM_CHANNELS-1:0]                 read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] read_address;
  logic [NUM_CHANNELS-1:0]                 read_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] read_data;
  logic [NUM_CHANNELS-1:0]                 write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] write_address;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] write_data;
  logic [NUM_CHANNELS-1:0]                 write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the GPU data-memory interface. The module
//   serialises N channels of independent read/write requests onto one
//   single-port word RAM, with one access per cycle and round-robin
//   arbitration. Each request is answered with a 4-phase valid/ready handshake.
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous active-low reset (0 = in reset)
//     bus         data_mem_responder_if.slave (per-channel handshakes)
//     addr_error  sticky flag: a granted access had address >= DEPTH
//     read_count  number of granted reads (wraps)
//     write_count number of granted writes (wraps)
//   Optional feature macro: DATA_MEM_RESPONDER_STATS_EN
//     When it is defined, addr_error/read_count/write_count are live.
//     When it is undefined, these outputs are tied to 0 and no counters exist.
//   The RAM contents are not cleared by reset.
module data_mem_responder #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  data_mem_responder_if.slave    bus,
  output logic                   addr_error,
  output logic [31:0]            read_count,
  output logic [31:0]            write_count
);

  localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t                                  r_rd_state [NUM_CHANNELS];
  state_t                                  r_wr_state [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                 r_read_ready;
  logic [NUM_CHANNELS-1:0]                 r_write_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] r_read_data;
  logic [PW-1:0]                           r_ptr;
  logic [DATA_WIDTH-1:0]                   r_mem [DEPTH];

  logic [NUM_CHANNELS-1:0] w_rd_pend;
  logic [NUM_CHANNELS-1:0] w_wr_pend;
  logic [NUM_CHANNELS-1:0] w_cand;
  logic                    w_gnt_valid;
  logic [PW-1:0]           w_gnt_ch;
  logic                    w_gnt_write;
  logic [ADDR_WIDTH-1:0]   w_gnt_addr;
  logic [DATA_WIDTH-1:0]   w_gnt_wdata;
  logic [MW-1:0]           w_mem_idx;
  logic                    w_in_range;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [NUM_CHANNELS-1:0] w_rd_gnt;
  logic [NUM_CHANNELS-1:0] w_wr_gnt;
  logic [PW-1:0]           w_ptr_next;
  int                      w_idx;

  assign bus.read_ready  = r_read_ready;
  assign bus.write_ready = r_write_ready;
  assign bus.read_data   = r_read_data;

  // Pending flags per channel and the set of channels competing this cycle.
  always_comb begin
    w_rd_pend = '0;
    w_wr_pend = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_rd_pend[i] = (r_rd_state[i] == ST_PEND);
      w_wr_pend[i] = (r_wr_state[i] == ST_PEND);
    end
    w_cand = w_rd_pend | w_wr_pend;
  end

  // Round-robin search starting at r_ptr; the first pending channel wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_ch    = '0;
    w_idx       = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_CHANNELS) begin
        w_idx = w_idx - NUM_CHANNELS;
      end else begin
        w_idx = w_idx;
      end
      if (!w_gnt_valid && w_cand[w_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_ch    = PW'(w_idx);
      end else begin
        w_gnt_valid = w_gnt_valid;
      end
    end
  end

  // Grant decode. Inside the winning channel a write beats a read.
  always_comb begin
    w_gnt_write = w_gnt_valid & w_wr_pend[w_gnt_ch];
    w_gnt_addr  = w_gnt_write ? bus.write_address[w_gnt_ch] : bus.read_address[w_gnt_ch];
    w_gnt_wdata = bus.write_data[w_gnt_ch];
    w_mem_idx   = w_gnt_addr[MW-1:0];
    w_in_range  = (32'(w_gnt_addr) < 32'(DEPTH));
    w_rd_word   = w_in_range ? r_mem[w_mem_idx] : {DATA_WIDTH{1'b0}};
    w_rd_gnt    = '0;
    w_wr_gnt    = '0;
    if (w_gnt_valid) begin
      if (w_gnt_write) begin
        w_wr_gnt[w_gnt_ch] = 1'b1;
      end else begin
        w_rd_gnt[w_gnt_ch] = 1'b1;
      end
    end else begin
      w_rd_gnt = '0;
    end
    if (w_gnt_ch == PW'(NUM_CHANNELS - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gnt_ch + PW'(1);
    end
  end

  // Single-port RAM write. There is no reset, so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_gnt_write && w_in_range) begin
      r_mem[w_mem_idx] <= w_gnt_wdata;
    end
  end

  // Per-channel read/write handshake FSMs, acknowledge outputs and pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_rd_state[i]  <= ST_IDLE;
        r_wr_state[i]  <= ST_IDLE;
        r_read_data[i] <= '0;
      end
      r_read_ready  <= '0;
      r_write_ready <= '0;
      r_ptr         <= '0;
    end else begin
      if (w_gnt_valid) begin
        r_ptr <= w_ptr_next;
      end else begin
        r_ptr <= r_ptr;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        case (r_wr_state[i])
          ST_IDLE: if (bus.write_valid[i]) r_wr_state[i] <= ST_PEND;
          ST_PEND: begin
            if (w_wr_gnt[i]) begin
              r_wr_state[i]    <= ST_ACK;
              r_write_ready[i] <= 1'b1;
            end
          end
          // 4-phase: leave ACK only once the initiator has dropped valid.
          ST_ACK: begin
            if (!bus.write_valid[i]) begin
              r_wr_state[i]    <= ST_IDLE;
              r_write_ready[i] <= 1'b0;
            end
          end
          default: begin
            r_wr_state[i]    <= ST_IDLE;
            r_write_ready[i] <= 1'b0;
          end
        endcase

        case (r_rd_state[i])
          ST_IDLE: if (bus.read_valid[i]) r_rd_state[i] <= ST_PEND;
          ST_PEND: begin
            if (w_rd_gnt[i]) begin
              r_rd_state[i]   <= ST_ACK;
              r_read_ready[i] <= 1'b1;
              r_read_data[i]  <= w_rd_word;
            end
          end
          ST_ACK: begin
            if (!bus.read_valid[i]) begin
              r_rd_state[i]   <= ST_IDLE;
              r_read_ready[i] <= 1'b0;
            end
          end
          default: begin
            r_rd_state[i]   <= ST_IDLE;
            r_read_ready[i] <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic        r_addr_error;
  logic [31:0] r_read_count;
  logic [31:0] r_write_count;

  // Access statistics. Out-of-range accesses are counted as well.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_error  <= 1'b0;
      r_read_count  <= 32'd0;
      r_write_count <= 32'd0;
    end else begin
      if (w_gnt_valid && !w_in_range) begin
        r_addr_error <= 1'b1;
      end else begin
        r_addr_error <= r_addr_error;
      end
      if (w_gnt_valid && w_gnt_write) begin
        r_write_count <= r_write_count + 32'd1;
      end else begin
        r_write_count <= r_write_count;
      end
      if (w_gnt_valid && !w_gnt_write) begin
        r_read_count <= r_read_count + 32'd1;
      end else begin
        r_read_count <= r_read_count;
      end
    end
  end

  assign addr_error  = r_addr_error;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`else
  assign addr_error  = 1'b0;
  assign read_count  = 32'd0;
  assign write_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int NCH = 8;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int DEP = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        addr_error;
  logic [31:0] read_count;
  logic [31:0] write_count;

  always #5 clk = ~clk;

  data_mem_responder_if #(.NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_responder #(.NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .addr_error(addr_error), .read_count(read_count), .write_count(write_count)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural reference state.
  logic [31:0] model_mem [256];
  bit          model_known [256];
  int          tb_ptr = 0;
  int          exp_rd_total = 0;
  int          exp_wr_total = 0;
  bit          exp_addr_err = 1'b0;

  // Burst description.
  bit          b_rd [NCH];
  bit          b_wr [NCH];
  logic [7:0]  b_raddr [NCH];
  logic [7:0]  b_waddr [NCH];
  logic [31:0] b_wdata [NCH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    if (int'(a) >= DEP) return 32'd0;
    return model_mem[a];
  endfunction

  task automatic clear_burst();
    for (int i = 0; i < NCH; i++) begin
      b_rd[i] = 1'b0; b_wr[i] = 1'b0;
      b_raddr[i] = 8'd0; b_waddr[i] = 8'd0; b_wdata[i] = 32'd0;
    end
  endtask

  // Predicts the service slot of every request from the arbitration rules.
  // Then it drives the burst, and checks each ready cycle and each read word.
  task automatic run_burst(input string name);
    int          exp_w [NCH];
    int          exp_r [NCH];
    int          seen_w [NCH];
    int          seen_r [NCH];
    logic [31:0] exp_d [NCH];
    bit          rd_known [NCH];
    bit          pw [NCH];
    bit          pr [NCH];
    int          total;
    bit          found;
    total = 0;
    for (int i = 0; i < NCH; i++) begin
      pw[i] = b_wr[i]; pr[i] = b_rd[i];
      total += int'(b_wr[i]) + int'(b_rd[i]);
      exp_w[i] = -1; exp_r[i] = -1; seen_w[i] = -1; seen_r[i] = -1;
      exp_d[i] = 32'd0; rd_known[i] = 1'b0;
    end
    for (int slot = 0; slot < total; slot++) begin
      found = 1'b0;
      for (int k = 0; k < NCH && !found; k++) begin
        int c;
        c = (tb_ptr + k) % NCH;
        if (pw[c]) begin
          found = 1'b1; pw[c] = 1'b0; exp_w[c] = slot + 2; exp_wr_total++;
          if (int'(b_waddr[c]) < DEP) begin
            model_mem[b_waddr[c]] = b_wdata[c]; model_known[b_waddr[c]] = 1'b1;
          end else begin
            exp_addr_err = 1'b1;
          end
          tb_ptr = (c + 1) % NCH;
        end else if (pr[c]) begin
          found = 1'b1; pr[c] = 1'b0; exp_r[c] = slot + 2; exp_rd_total++;
          rd_known[c] = (int'(b_raddr[c]) >= DEP) || model_known[b_raddr[c]];
          exp_d[c] = exp_read(b_raddr[c]);
          if (int'(b_raddr[c]) >= DEP) exp_addr_err = 1'b1;
          tb_ptr = (c + 1) % NCH;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NCH; i++) begin
      bus.write_address[i] = b_waddr[i];
      bus.write_data[i]    = b_wdata[i];
      bus.read_address[i]  = b_raddr[i];
      bus.write_valid[i]   = b_wr[i];
      bus.read_valid[i]    = b_rd[i];
    end
    for (int cyc = 1; cyc <= 3 * NCH + 4; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (b_wr[i] && seen_w[i] < 0 && bus.write_ready[i]) begin
          seen_w[i] = cyc; bus.write_valid[i] = 1'b0;
        end
        if (b_rd[i] && seen_r[i] < 0 && bus.read_ready[i]) begin
          seen_r[i] = cyc;
          if (rd_known[i]) chk($sformatf("%s_rdata_ch%0d", name, i), bus.read_data[i], exp_d[i]);
          bus.read_valid[i] = 1'b0;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (b_wr[i]) chk($sformatf("%s_wlat_ch%0d", name, i), seen_w[i], exp_w[i]);
      if (b_rd[i]) chk($sformatf("%s_rlat_ch%0d", name, i), seen_r[i], exp_r[i]);
      bus.write_valid[i] = 1'b0; bus.read_valid[i] = 1'b0;
    end
    chk({name, "_ready_low"}, {bus.read_ready, bus.write_ready}, 64'd0);
  endtask

  task automatic single(input bit is_wr, input int ch, input logic [7:0] a, input logic [31:0] d, input string name);
    clear_burst();
    if (is_wr) begin
      b_wr[ch] = 1'b1; b_waddr[ch] = a; b_wdata[ch] = d;
    end else begin
      b_rd[ch] = 1'b1; b_raddr[ch] = a;
    end
    run_burst(name);
  endtask

  task automatic check_stats(input string name);
`ifdef DATA_MEM_RESPONDER_STATS_EN
    chk({name, "_addr_error"}, addr_error, exp_addr_err);
    chk({name, "_read_count"}, read_count, 32'(exp_rd_total));
    chk({name, "_write_count"}, write_count, 32'(exp_wr_total));
`else
    chk({name, "_stats_tied"}, {addr_error, read_count, write_count}, 65'd0);
`endif
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [31:0] held;
    for (int a = 0; a < 256; a++) begin model_mem[a] = 32'd0; model_known[a] = 1'b0; end
    bus.read_valid = '0; bus.write_valid = '0;
    bus.read_address = '0; bus.write_address = '0; bus.write_data = '0;

    // Reset, then idle.
    repeat (3) @(negedge clk);
    chk("rst_ready", {bus.read_ready, bus.write_ready}, 64'd0);
    for (int i = 0; i < NCH; i++) chk($sformatf("rst_rdata_ch%0d", i), bus.read_data[i], 32'd0);
    check_stats("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single write then read on ch0.
    single(1'b1, 0, 8'h10, 32'hDEADBEEF, "wr0");
    single(1'b0, 0, 8'h10, 32'd0, "rd0");
    chk("rd0_held_after_drop", bus.read_data[0], 32'hDEADBEEF);

    // Preload one address per channel; the last grant is ch7, so the pointer wraps to 0.
    for (int i = 0; i < NCH; i++) single(1'b1, i, 8'(8'h20 + 3 * i), $urandom, $sformatf("pre%0d", i));
    clear_burst();
    for (int i = 0; i < NCH; i++) begin b_rd[i] = 1'b1; b_raddr[i] = 8'(8'h20 + 3 * i); end
    run_burst("all8");

    // Move the pointer to ch3, then all channels read again.
    single(1'b0, 2, 8'h20, 32'd0, "ptrmove");
    clear_burst();
    for (int i = 0; i < NCH; i++) begin b_rd[i] = 1'b1; b_raddr[i] = 8'(8'h20 + 3 * i); end
    run_burst("from3");

    // Same-channel write and read to one address.
    clear_burst();
    b_wr[2] = 1'b1; b_rd[2] = 1'b1; b_waddr[2] = 8'h05; b_raddr[2] = 8'h05; b_wdata[2] = 32'h1234;
    run_burst("rw2");
    chk("rw2_data", bus.read_data[2], 32'h1234);

    // Random bursts.
    for (int it = 0; it < 6; it++) begin
      clear_burst();
      for (int i = 0; i < NCH; i++) begin
        int sel;
        sel = $urandom_range(0, 3);
        b_wr[i] = (sel == 1) || (sel == 3);
        b_rd[i] = (sel == 2) || (sel == 3);
        b_waddr[i] = ($urandom_range(0, 7) == 0) ? 8'(200 + 6 * i + $urandom_range(0, 5))
                                                 : 8'(8 * i + $urandom_range(0, 7));
        b_wdata[i] = $urandom;
        b_raddr[i] = (sel == 3) ? b_waddr[i] : 8'(8 * i + $urandom_range(0, 7));
      end
      run_burst($sformatf("rnd%0d", it));
    end
    check_stats("after_rnd");

    // Held valid: one access only, ready stays high until valid drops.
    single(1'b1, 1, 8'h30, 32'hA5A5_0001, "hold_pre");
    @(negedge clk);
    bus.read_address[1] = 8'h30; bus.read_valid[1] = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.read_ready[1]) lat = c;
    end
    chk("hold_lat", lat, 2);
    exp_rd_total++; tb_ptr = 2;
    held = bus.read_data[1];
    chk("hold_data", held, 32'hA5A5_0001);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.read_ready[1] || bus.read_data[1] !== held) bad++;
    end
    chk("hold_stable", bad, 0);
    check_stats("hold");
    bus.read_valid[1] = 1'b0;
    @(negedge clk);
    chk("hold_drop_ready", bus.read_ready[1], 1'b0);

    // Out-of-range write and read.
    single(1'b1, 0, 8'd250, 32'hCAFE_F00D, "oor_wr");
    single(1'b0, 0, 8'd250, 32'd0, "oor_rd");
    chk("oor_rdata", bus.read_data[0], 32'd0);
    check_stats("oor");

    // Reset during ACK, then check that the RAM keeps its contents.
    single(1'b1, 4, 8'hC0, 32'h0BAD_F00D, "mid_pre");
    @(negedge clk);
    bus.read_address[3] = 8'hC0; bus.read_valid[3] = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.read_ready[3]) lat = c;
    end
    chk("mid_lat", lat, 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", bus.read_ready[3], 1'b0);
    chk("mid_rst_rdata", bus.read_data[3], 32'd0);
    tb_ptr = 0; exp_rd_total = 0; exp_wr_total = 0; exp_addr_err = 1'b0;
    check_stats("mid_rst");
    bus.read_valid[3] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    single(1'b0, 3, 8'hC0, 32'd0, "post_rst_rd");
    chk("post_rst_data", bus.read_data[3], 32'h0BAD_F00D);
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
